pcie_mem_arbiter: RTL and testbench
===================================

# pcie_mem_arbiter

Two-port arbiter and sequencer in front of the PIO register/BRAM access port (BAR0 adapter registers, BAR2 scratch BRAM). It shares that single rd/wr port between requester 0 (PCIe PIO target engine) and requester 1 (NetTLP Ethernet-side register access path) with round-robin priority. It generates the two-cycle address-hold read sequence and the busy-aware write strobe the port requires, and returns read data to the winning requester.

## Interface
- BUSY_TIMEOUT, 16'd255: max consecutive cycles a write may stall on mem_wr_busy before it is dropped (1..65535)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- reqN_valid (N=0,1)  in  1  request pending; held until accepted
- reqN_ready  out  1  accept strobe; transfer when valid&ready
- reqN_wr  in  1  1=write, 0=read
- reqN_addr  in  14  DW address ([13:12] selects BAR)
- reqN_be  in  4  byte enables
- reqN_wdata  in  32  write data
- respN_valid  out  1  one-cycle read-data strobe
- respN_data  out  32  read data, valid with respN_valid
- mem_rd_addr  out  14  to port rd_addr
- mem_rd_be  out  4  to port rd_be
- mem_rd_data  in  32  from port rd_data
- mem_wr_en  out  1  to port wr_en
- mem_wr_addr  out  14  to port wr_addr
- mem_wr_be  out  8  to port wr_be; {4'b0, be}
- mem_wr_data  out  32  to port wr_data
- mem_wr_busy  in  1  from port wr_busy
- err_wr_timeout  out  1  sticky: a write was dropped on timeout; cleared only by rst

## Operation
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA.
- IDLE: if any reqN_valid, choose winner, assert winner's reqN_ready combinationally in the same cycle, latch wr/addr/be/wdata and the winner id, and go to WRITE (wr=1) or RD_ADDR (wr=0). The loser's ready stays 0.
- Arbitration: 1-bit pointer prio. If both valid, prio wins. If only one valid, it wins. After any grant, prio becomes the non-winner. Reset prio=0.
- WRITE:
  - Drive mem_wr_en=1 with the latched addr/be/data.
  - mem_wr_busy=0: write completes; reset the stall counter and go to IDLE.
  - mem_wr_busy=1: stay in WRITE and increment the stall counter. When the counter reaches BUSY_TIMEOUT, drop the write, set err_wr_timeout, and go to IDLE.
- RD_ADDR: mem_wr_en=0; drive mem_rd_addr/mem_rd_be from the latched values; go to RD_DATA.
- RD_DATA: hold mem_rd_addr/mem_rd_be, mem_wr_en=0. On the clock edge ending this state, register mem_rd_data into respN_data of the latched winner. Pulse respN_valid in the following cycle, then go to IDLE.
- Address/data outputs hold their last value when unused. Only mem_wr_en qualifies writes.
- No address-range checking: reads of unmapped BARs return whatever the port returns (0).
- respN_data holds its value between reads. The non-winner's resp is untouched.

## Timing
- Reset values:
  - state=IDLE, prio=0, stall counter=0.
  - mem_wr_en=0, mem_rd_addr=0, mem_rd_be=0, mem_wr_addr=0, mem_wr_be=0, mem_wr_data=0.
  - reqN_ready=0, respN_valid=0, respN_data=0, err_wr_timeout=0.
- Read (accepted cycle 0):
  - Cycle 1: RD_ADDR.
  - Cycle 2: RD_DATA; mem_rd_data sampled at its end.
  - Cycle 3: respN_valid=1, state IDLE; a new accept is possible in cycle 3.
- Write (accepted cycle 0), no busy: mem_wr_en=1 in cycle 1; next accept in cycle 2. Peak rate is one write per 2 cycles.
- Write with busy: mem_wr_en stays high for every busy cycle plus the final non-busy cycle. With busy stuck high, mem_wr_en stays high for exactly BUSY_TIMEOUT cycles, then drops.
- reqN_ready is only ever asserted in IDLE, at most one requester per cycle.
- Reset asserted mid-operation aborts the access:
  - next cycle IDLE, mem_wr_en=0, no resp pulse
  - err_wr_timeout cleared
  - pending requesters re-arbitrate from prio=0

## Test plan
- Single read, req0 addr 0x1000 (BAR0 magic 0x01234567): ready0 at cycle 0; mem_rd_addr=0x1000 held in cycles 1–2; resp0_valid in cycle 3 with resp0_data=0x67452301.
- Write then read-back, req1 write addr 0x2005 be 0xF data 0xDEADBEEF, then read 0x2005: mem_wr_en one cycle with mem_wr_be=0x0F; resp1_data=0xDEADBEEF.
- Both valid continuously, reads: grants alternate 0,1,0,1 starting with 0 after reset; no requester is granted twice in a row; each resp goes only to its own port.
- Busy stall, mem_wr_busy high 3 cycles then low: mem_wr_en high 4 cycles; err_wr_timeout stays 0.
- Timeout, BUSY_TIMEOUT=4, busy stuck high: mem_wr_en high exactly 4 cycles; err_wr_timeout=1 and stays set; the following read completes normally.
- Reset in RD_DATA: no resp pulse, all outputs return to reset values, prio=0.

Source files
------------

// File: rtl/pcie_mem_arbiter.sv
// ============================================================================
// pcie_mem_arbiter : round-robin arbiter/sequencer sharing the PIO rd/wr port
// Revision: 1.0
// ============================================================================
`default_nettype none

module pcie_mem_arbiter #(
    parameter logic [15:0] BUSY_TIMEOUT = 16'd255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic        req0_wr_i,
    input  logic [13:0] req0_addr_i,
    input  logic [3:0]  req0_be_i,
    input  logic [31:0] req0_wdata_i,
    output logic        resp0_valid_o,
    output logic [31:0] resp0_data_o,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic        req1_wr_i,
    input  logic [13:0] req1_addr_i,
    input  logic [3:0]  req1_be_i,
    input  logic [31:0] req1_wdata_i,
    output logic        resp1_valid_o,
    output logic [31:0] resp1_data_o,

    output logic [13:0] mem_rd_addr_o,
    output logic [3:0]  mem_rd_be_o,
    input  logic [31:0] mem_rd_data_i,
    output logic        mem_wr_en_o,
    output logic [13:0] mem_wr_addr_o,
    output logic [7:0]  mem_wr_be_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_wr_busy_i,
    output logic        err_wr_timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RD_ADDR = 2'd2,
        S_RD_DATA = 2'd3
    } state_t;

    // Last stall count value before the write is abandoned.
    localparam logic [15:0] c_STALL_LAST = BUSY_TIMEOUT - 16'd1;

    state_t      state_q;
    logic        prio_q;
    logic        id_q;
    logic [15:0] stall_q;
    logic        wr_en_q;
    logic [13:0] wr_addr_q;
    logic [7:0]  wr_be_q;
    logic [31:0] wr_data_q;
    logic [13:0] rd_addr_q;
    logic [3:0]  rd_be_q;
    logic        resp0_valid_q;
    logic        resp1_valid_q;
    logic [31:0] resp0_data_q;
    logic [31:0] resp1_data_q;
    logic        err_q;

    logic        w_grant;
    logic        w_win;
    logic        w_sel_wr;
    logic [13:0] w_sel_addr;
    logic [3:0]  w_sel_be;
    logic [31:0] w_sel_wdata;

    always_comb begin
        w_win       = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
        w_grant     = (state_q == S_IDLE) && !rst && (req0_valid_i || req1_valid_i);
        w_sel_wr    = w_win ? req1_wr_i    : req0_wr_i;
        w_sel_addr  = w_win ? req1_addr_i  : req0_addr_i;
        w_sel_be    = w_win ? req1_be_i    : req0_be_i;
        w_sel_wdata = w_win ? req1_wdata_i : req0_wdata_i;
    end

    assign req0_ready_o = w_grant && !w_win;
    assign req1_ready_o = w_grant &&  w_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            prio_q        <= 1'b0;
            id_q          <= 1'b0;
            stall_q       <= 16'd0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 14'd0;
            wr_be_q       <= 8'd0;
            wr_data_q     <= 32'd0;
            rd_addr_q     <= 14'd0;
            rd_be_q       <= 4'd0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_data_q  <= 32'd0;
            resp1_data_q  <= 32'd0;
            err_q         <= 1'b0;
        end else begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_grant) begin
                        prio_q <= ~w_win;
                        id_q   <= w_win;
                        if (w_sel_wr) begin
                            state_q   <= S_WRITE;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= w_sel_addr;
                            wr_be_q   <= {4'b0000, w_sel_be};
                            wr_data_q <= w_sel_wdata;
                        end else begin
                            state_q   <= S_RD_ADDR;
                            rd_addr_q <= w_sel_addr;
                            rd_be_q   <= w_sel_be;
                        end
                    end
                end
                S_WRITE: begin
                    // A stuck busy drops the write once it has been held BUSY_TIMEOUT cycles.
                    if (!mem_wr_busy_i) begin
                        wr_en_q <= 1'b0;
                        stall_q <= 16'd0;
                        state_q <= S_IDLE;
                    end else if (stall_q == c_STALL_LAST) begin
                        wr_en_q <= 1'b0;
                        stall_q <= 16'd0;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        stall_q <= stall_q + 16'd1;
                    end
                end
                S_RD_ADDR: begin
                    state_q <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (id_q) begin
                        resp1_data_q  <= mem_rd_data_i;
                        resp1_valid_q <= 1'b1;
                    end else begin
                        resp0_data_q  <= mem_rd_data_i;
                        resp0_valid_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_addr_o    = rd_addr_q;
    assign mem_rd_be_o      = rd_be_q;
    assign mem_wr_en_o      = wr_en_q;
    assign mem_wr_addr_o    = wr_addr_q;
    assign mem_wr_be_o      = wr_be_q;
    assign mem_wr_data_o    = wr_data_q;
    assign resp0_valid_o    = resp0_valid_q;
    assign resp1_valid_o    = resp1_valid_q;
    assign resp0_data_o     = resp0_data_q;
    assign resp1_data_o     = resp1_data_q;
    assign err_wr_timeout_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pcie_mem_arbiter.sv
// ============================================================================
// tb_pcie_mem_arbiter : directed + randomized bench with a transaction model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pcie_mem_arbiter;

    localparam logic [15:0] TMO = 16'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  v;
    logic [1:0]  wr;
    logic [13:0] addr [2];
    logic [3:0]  be   [2];
    logic [31:0] wd   [2];
    logic [1:0]  rdy;
    logic [1:0]  rv;
    logic [31:0] rdat [2];
    logic [13:0] mem_rd_addr;
    logic [3:0]  mem_rd_be;
    logic [31:0] prd_q;
    logic        mem_wr_en;
    logic [13:0] mem_wr_addr;
    logic [7:0]  mem_wr_be;
    logic [31:0] mem_wr_data;
    logic        busy;
    logic        err;

    pcie_mem_arbiter #(.BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(v[0]), .req0_ready_o(rdy[0]), .req0_wr_i(wr[0]),
        .req0_addr_i(addr[0]), .req0_be_i(be[0]), .req0_wdata_i(wd[0]),
        .resp0_valid_o(rv[0]), .resp0_data_o(rdat[0]),
        .req1_valid_i(v[1]), .req1_ready_o(rdy[1]), .req1_wr_i(wr[1]),
        .req1_addr_i(addr[1]), .req1_be_i(be[1]), .req1_wdata_i(wd[1]),
        .resp1_valid_o(rv[1]), .resp1_data_o(rdat[1]),
        .mem_rd_addr_o(mem_rd_addr), .mem_rd_be_o(mem_rd_be), .mem_rd_data_i(prd_q),
        .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_be_o(mem_wr_be),
        .mem_wr_data_o(mem_wr_data), .mem_wr_busy_i(busy), .err_wr_timeout_o(err)
    );

    // Port model: only BAR regions 1 and 2 are backed; one-cycle registered read.
    logic [31:0] pmem [0:16383];
    logic [31:0] mmem [0:16383];

    function automatic bit mapped(input logic [13:0] a);
        return (a[13:12] == 2'd1) || (a[13:12] == 2'd2);
    endfunction

    always @(posedge clk) begin
        prd_q <= mapped(mem_rd_addr) ? pmem[mem_rd_addr] : 32'h0;
        if (mem_wr_en && !busy && mapped(mem_wr_addr))
            for (int b = 0; b < 4; b++)
                if (mem_wr_be[b]) pmem[mem_wr_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: each accepted op is timed by offsets from its accept cycle.
    bit          op_act, op_wr, op_p, mprio;
    logic [13:0] op_a;
    logic [3:0]  op_be;
    logic [31:0] op_d;
    int          op_acc, stall, cyc;
    bit          e_wen, e_err;
    logic [1:0]  e_rv;
    logic [13:0] e_wa, e_ra;
    logic [3:0]  e_wbe, e_rbe;
    logic [31:0] e_wd;
    logic [31:0] e_rdat [2];

    task automatic commit_write();
        if (mapped(op_a))
            for (int b = 0; b < 4; b++)
                if (op_be[b]) mmem[op_a][8*b +: 8] = op_d[8*b +: 8];
    endtask

    task automatic model_reset();
        op_act = 0; mprio = 0; stall = 0;
        e_wen = 0; e_err = 0; e_rv = 2'b00;
        e_wa = '0; e_ra = '0; e_wbe = '0; e_rbe = '0; e_wd = '0;
        e_rdat[0] = '0; e_rdat[1] = '0;
    endtask

    initial begin : compare
        bit seen;
        bit g;
        int w;
        seen = 0; cyc = 0;
        model_reset();
        forever begin
            @(negedge clk);
            g = !rst && !op_act && (v != 2'b00);
            w = (v == 2'b11) ? int'(mprio) : int'(v[1]);
            if (seen) begin
                chk("ready0",      32'(rdy[0]),    32'(g && w == 0));
                chk("ready1",      32'(rdy[1]),    32'(g && w == 1));
                chk("wr_en",       32'(mem_wr_en), 32'(e_wen));
                chk("wr_addr",     32'(mem_wr_addr), 32'(e_wa));
                chk("wr_be",       32'(mem_wr_be), {24'd0, 4'd0, e_wbe});
                chk("wr_data",     mem_wr_data,    e_wd);
                chk("rd_addr",     32'(mem_rd_addr), 32'(e_ra));
                chk("rd_be",       32'(mem_rd_be), 32'(e_rbe));
                chk("resp0_valid", 32'(rv[0]),     32'(e_rv[0]));
                chk("resp1_valid", 32'(rv[1]),     32'(e_rv[1]));
                chk("resp0_data",  rdat[0],        e_rdat[0]);
                chk("resp1_data",  rdat[1],        e_rdat[1]);
                chk("err_timeout", 32'(err),       32'(e_err));
            end
            e_rv = 2'b00;
            if (rst) begin
                if (op_act && op_wr && !busy) commit_write();
                seen = 1;
                model_reset();
            end else begin
                if (op_act) begin
                    if (op_wr) begin
                        if (!busy) begin
                            commit_write(); op_act = 0; e_wen = 0; stall = 0;
                        end else begin
                            stall++;
                            if (stall == int'(TMO)) begin
                                e_err = 1; e_wen = 0; op_act = 0; stall = 0;
                            end
                        end
                    end else if (cyc == op_acc + 2) begin
                        e_rv[op_p]   = 1'b1;
                        e_rdat[op_p] = mapped(op_a) ? mmem[op_a] : 32'h0;
                        op_act = 0;
                    end
                end
                if (g) begin
                    op_act = 1; op_acc = cyc; op_p = (w == 1); mprio = (w == 0);
                    op_wr = wr[w]; op_a = addr[w]; op_be = be[w]; op_d = wd[w];
                    if (op_wr) begin
                        e_wen = 1; e_wa = op_a; e_wbe = op_be; e_wd = op_d; stall = 0;
                    end else begin
                        e_ra = op_a; e_rbe = op_be;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic do_req(input int p, input bit w, input logic [13:0] a,
                          input logic [3:0] b, input logic [31:0] d);
        int n;
        v[p] = 1'b1; wr[p] = w; addr[p] = a; be[p] = b; wd[p] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[p] && n < 40);
        chk("accept", 32'(rdy[p]), 32'd1);
        @(posedge clk); #1;
        v[p] = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        int cnt;
        int gs[$];
        int stuck;
        logic [1:0] acc;
        v = 2'b00; wr = 2'b00; busy = 1'b0;
        for (int p = 0; p < 2; p++) begin addr[p] = '0; be[p] = '0; wd[p] = '0; end
        for (int i = 0; i < 16384; i++) begin pmem[i] = 32'h0; mmem[i] = 32'h0; end
        pmem[14'h1000] = 32'h67452301; mmem[14'h1000] = 32'h67452301;
        pmem[14'h1001] = 32'h0BADF00D; mmem[14'h1001] = 32'h0BADF00D;
        pmem[14'h1002] = 32'hCAFEF00D; mmem[14'h1002] = 32'hCAFEF00D;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_en",   32'(mem_wr_en),   32'd0);
        chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        chk("rst_resp0",   rdat[0],          32'd0);
        chk("rst_err",     32'(err),         32'd0);
        @(posedge clk); #1;

        // single read of the BAR0 magic word
        do_req(0, 1'b0, 14'h1000, 4'hF, 32'h0);
        @(negedge clk); chk("rd_c1_addr", 32'(mem_rd_addr), 32'h1000);
        @(negedge clk); chk("rd_c2_addr", 32'(mem_rd_addr), 32'h1000);
                        chk("rd_c2_noresp", 32'(rv[0]), 32'd0);
        @(negedge clk); chk("rd_c3_valid", 32'(rv[0]), 32'd1);
                        chk("rd_c3_data", rdat[0], 32'h67452301);
        @(posedge clk); #1;

        // write then read-back on requester 1
        do_req(1, 1'b1, 14'h2005, 4'hF, 32'hDEADBEEF);
        @(negedge clk); chk("wr_c1_en", 32'(mem_wr_en), 32'd1);
                        chk("wr_c1_be", 32'(mem_wr_be), 32'h0F);
        @(negedge clk); chk("wr_c2_en", 32'(mem_wr_en), 32'd0);
        @(posedge clk); #1;
        do_req(1, 1'b0, 14'h2005, 4'hF, 32'h0);
        repeat (3) @(negedge clk);
        chk("rb_valid", 32'(rv[1]), 32'd1);
        chk("rb_data",  rdat[1],    32'hDEADBEEF);
        @(posedge clk); #1;

        // busy for three cycles then released
        busy = 1'b1;
        do_req(0, 1'b1, 14'h2010, 4'h3, 32'h12345678);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); if (mem_wr_en) cnt++;
            @(posedge clk); #1; if (i == 2) busy = 1'b0;
        end
        chk("stall_wen_cycles", 32'(cnt), 32'd4);
        chk("stall_err", 32'(err), 32'd0);

        // busy stuck: write dropped after TMO cycles
        busy = 1'b1;
        do_req(1, 1'b1, 14'h2011, 4'hF, 32'hFFFFFFFF);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); if (mem_wr_en) cnt++;
            @(posedge clk); #1; if (i == 7) busy = 1'b0;
        end
        chk("tmo_wen_cycles", 32'(cnt), 32'd4);
        chk("tmo_err", 32'(err), 32'd1);
        do_req(1, 1'b0, 14'h2010, 4'hF, 32'h0);
        repeat (3) @(negedge clk);
        chk("tmo_rd_valid", 32'(rv[1]), 32'd1);
        chk("tmo_rd_data",  rdat[1],    32'h00005678);
        chk("tmo_err_sticky", 32'(err), 32'd1);
        @(posedge clk); #1;

        // reset during RD_DATA
        do_req(0, 1'b0, 14'h1001, 4'hF, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rrst_noresp", 32'(rv[0]),       32'd0);
        chk("rrst_rd_addr", 32'(mem_rd_addr), 32'd0);
        chk("rrst_resp0",  rdat[0],          32'd0);
        chk("rrst_err",    32'(err),         32'd0);
        @(posedge clk); #1;

        // both requesters reading continuously: grants alternate from 0
        v = 2'b11; wr = 2'b00;
        addr[0] = 14'h1000; addr[1] = 14'h2005; be[0] = 4'hF; be[1] = 4'hF;
        for (int i = 0; i < 40 && gs.size() < 4; i++) begin
            @(negedge clk);
            if (rdy[0]) gs.push_back(0);
            if (rdy[1]) gs.push_back(1);
            @(posedge clk); #1;
        end
        v = 2'b00;
        chk("alt_grant_count", 32'(gs.size()), 32'd4);
        for (int k = 0; k < gs.size(); k++) chk("alt_grant_order", 32'(gs[k]), 32'(k % 2));
        repeat (5) @(posedge clk); #1;

        // randomized traffic, busy stalls, timeouts and occasional resets
        stuck = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            acc = v & rdy & {2{!rst}};
            @(posedge clk); #1;
            rst = ($urandom_range(0, 249) == 0);
            for (int p = 0; p < 2; p++) begin
                if (acc[p] || !v[p]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        v[p]    = 1'b1;
                        wr[p]   = 1'($urandom_range(0, 1));
                        addr[p] = {2'($urandom_range(0, 3)), 9'd0, 3'($urandom_range(0, 7))};
                        be[p]   = 4'($urandom_range(0, 15));
                        wd[p]   = $urandom;
                    end else begin
                        v[p] = 1'b0;
                    end
                end
            end
            if (stuck > 0) begin
                busy = 1'b1; stuck--;
            end else if ($urandom_range(0, 39) == 0) begin
                busy = 1'b1; stuck = 6;
            end else begin
                busy = ($urandom_range(0, 3) == 0);
            end
        end
        v = 2'b00; busy = 1'b0; rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
